// File: rtl/drain_ctrl_pkg.sv
// rtl/drain_ctrl_pkg.sv - shared types, sizes and C address helper for drain_ctrl
package drain_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    localparam int DEF_N1     = 4;
    localparam int DEF_N2     = 4;
    localparam int MS_W       = 16;
    localparam int PROD_W     = 2 * MS_W;
    localparam int TILE_ELEMS = DEF_N1 * DEF_N2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (s*N1 + i)*M3 + p*N2 + j, computed at double width; callers truncate
    function automatic logic [PROD_W-1:0] calc_c_addr(
        input logic [MS_W-1:0] s,
        input logic [MS_W-1:0] p,
        input logic [MS_W-1:0] i,
        input logic [MS_W-1:0] j,
        input logic [MS_W-1:0] m3,
        input int              n1,
        input int              n2
    );
        logic [PROD_W-1:0] row;
        logic [PROD_W-1:0] col;
        row = PROD_W'(s) * PROD_W'(n1) + PROD_W'(i);
        col = PROD_W'(p) * PROD_W'(n2) + PROD_W'(j);
        return row * PROD_W'(m3) + col;
    endfunction

endpackage

// File: rtl/drain_ctrl_if.sv
// rtl/drain_ctrl_if.sv - C buffer write port between drain_ctrl and the output buffer
interface drain_ctrl_if
    import drain_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W_C = 12
);
    logic                wr_en;
    logic                wr_ready;
    logic [ADDR_W_C-1:0] wr_addr;
    logic [DATA_W-1:0]   wr_data;

    modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/drain_ctrl_tile_bank.sv
// rtl/drain_ctrl_tile_bank.sv - one N1xN2 result bank with full flag and (i, j) read mux
module tile_bank
    import drain_ctrl_pkg::*;
#(
    parameter int  N1     = 4,
    parameter int  N2     = 4,
    parameter int  DATA_W = 32,
    localparam int IW     = idx_w(N1),
    localparam int JW     = idx_w(N2)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_load,
    input  logic                             i_clr,
    input  logic [N1-1:0][N2-1:0][DATA_W-1:0] i_data,
    input  logic [IW-1:0]                    i_i,
    input  logic [JW-1:0]                    i_j,
    output logic                             o_full,
    output logic [DATA_W-1:0]                o_word
);
    logic                             r_full;
    logic [N1-1:0][N2-1:0][DATA_W-1:0] r_mem;

    // load beats clear so a bank can be refilled on the cycle it is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_mem <= i_data;
        end
    end

    assign o_full = r_full;
    assign o_word = r_mem[i_i][i_j];

endmodule

// File: rtl/drain_ctrl.sv
// rtl/drain_ctrl.sv - snapshots finished array tiles and streams them row-major into C
module drain_ctrl
    import drain_ctrl_pkg::*;
#(
    parameter int N1           = DEF_N1,
    parameter int N2           = DEF_N2,
    parameter int DATA_W       = 32,
    parameter int MATRIXSIZE_W = MS_W,
    parameter int ADDR_W_C     = 12
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [MATRIXSIZE_W-1:0]           M3,
    input  logic [MATRIXSIZE_W-1:0]           M1dN1,
    input  logic [MATRIXSIZE_W-1:0]           M3dN2,
    input  logic                              tile_done,
    input  logic [N1-1:0][N2-1:0][DATA_W-1:0] pe_result,
    drain_ctrl_if.master                      wr,
    output logic                              busy,
    output logic                              done,
    output logic                              overflow
);
    localparam int IW = idx_w(N1);
    localparam int JW = idx_w(N2);

    drain_state_t            r_state;
    drain_state_t            w_next;
    logic                    r_act;
    logic [IW-1:0]           r_i;
    logic [JW-1:0]           r_j;
    logic [MATRIXSIZE_W-1:0] r_s;
    logic [MATRIXSIZE_W-1:0] r_p;
    logic                    r_wr_en;
    logic [ADDR_W_C-1:0]     r_wr_addr;
    logic [DATA_W-1:0]       r_wr_data;
    logic                    r_done;
    logic                    r_ovf;

    logic [1:0]              w_full;
    logic [1:0]              w_load;
    logic [1:0]              w_clr;
    logic [DATA_W-1:0]       w_word [2];
    logic                    w_pend_full;
    logic                    w_xfer;
    logic                    w_last;
    logic                    w_release;
    logic                    w_cap_act;
    logic                    w_cap_pend;
    logic                    w_swap;
    logic                    w_emit;
    logic                    w_stop;
    logic                    w_src_pe;
    logic                    w_ovf_set;
    logic                    w_new_tile;
    logic                    w_rd_bank;
    logic [IW-1:0]           w_i_nxt;
    logic [JW-1:0]           w_j_nxt;
    logic [MATRIXSIZE_W-1:0] w_s_nxt;
    logic [MATRIXSIZE_W-1:0] w_p_nxt;
    logic                    w_run_end;
    logic [ADDR_W_C-1:0]     w_addr_nxt;
    logic [DATA_W-1:0]       w_data_nxt;

    // Ping-pong banks: r_act names the active bank, the other one is pending
    tile_bank #(.N1(N1), .N2(N2), .DATA_W(DATA_W)) u_bank0 (
        .clk(clk), .rst_n(rst_n), .i_load(w_load[0]), .i_clr(w_clr[0]), .i_data(pe_result),
        .i_i(w_i_nxt), .i_j(w_j_nxt), .o_full(w_full[0]), .o_word(w_word[0])
    );

    tile_bank #(.N1(N1), .N2(N2), .DATA_W(DATA_W)) u_bank1 (
        .clk(clk), .rst_n(rst_n), .i_load(w_load[1]), .i_clr(w_clr[1]), .i_data(pe_result),
        .i_i(w_i_nxt), .i_j(w_j_nxt), .o_full(w_full[1]), .o_word(w_word[1])
    );

    assign w_pend_full = r_act ? w_full[0] : w_full[1];
    assign w_xfer      = r_wr_en && wr.wr_ready;
    assign w_last      = (r_i == IW'(N1 - 1)) && (r_j == JW'(N2 - 1));
    assign w_release   = (r_state == DRAIN) && w_xfer && w_last;
    assign w_load[0]   = r_act ? w_cap_pend : w_cap_act;
    assign w_load[1]   = r_act ? w_cap_act : w_cap_pend;
    assign w_clr[0]    = w_release && !r_act;
    assign w_clr[1]    = w_release && r_act;
    assign w_new_tile  = w_swap || w_src_pe;
    assign w_rd_bank   = w_swap ? ~r_act : r_act;

    always_comb begin
        w_next     = r_state;
        w_cap_act  = 1'b0;
        w_cap_pend = 1'b0;
        w_swap     = 1'b0;
        w_emit     = 1'b0;
        w_stop     = 1'b0;
        w_src_pe   = 1'b0;
        w_ovf_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pend_full) begin
                    // promote; a new tile lands in the freed slot behind it
                    w_swap    = 1'b1;
                    w_emit    = 1'b1;
                    w_next    = DRAIN;
                    w_cap_act = tile_done;
                end else if (tile_done) begin
                    w_cap_act = 1'b1;
                    w_src_pe  = 1'b1;
                    w_emit    = 1'b1;
                    w_next    = DRAIN;
                end
            end
            DRAIN: begin
                if (w_release) begin
                    if (w_pend_full) begin
                        w_swap    = 1'b1;
                        w_emit    = 1'b1;
                        w_cap_act = tile_done;
                    end else begin
                        w_stop     = 1'b1;
                        w_next     = IDLE;
                        w_cap_pend = tile_done;
                    end
                end else begin
                    w_emit     = w_xfer;
                    w_cap_pend = tile_done && !w_pend_full;
                    w_ovf_set  = tile_done && w_pend_full;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_i_nxt = r_i;
        w_j_nxt = r_j;
        if (w_new_tile) begin
            w_i_nxt = '0;
            w_j_nxt = '0;
        end else if (r_j == JW'(N2 - 1)) begin
            w_j_nxt = '0;
            w_i_nxt = r_i + IW'(1);
        end else begin
            w_j_nxt = r_j + JW'(1);
        end
    end

    always_comb begin
        w_s_nxt   = r_s;
        w_p_nxt   = r_p;
        w_run_end = 1'b0;
        if (w_release) begin
            if (r_p == M3dN2 - MATRIXSIZE_W'(1)) begin
                w_p_nxt = '0;
                if (r_s == M1dN1 - MATRIXSIZE_W'(1)) begin
                    w_s_nxt   = '0;
                    w_run_end = 1'b1;
                end else begin
                    w_s_nxt = r_s + MATRIXSIZE_W'(1);
                end
            end else begin
                w_p_nxt = r_p + MATRIXSIZE_W'(1);
            end
        end
        if (start) begin
            w_s_nxt   = '0;
            w_p_nxt   = '0;
            w_run_end = 1'b0;
        end
    end

    // Address uses post-advance s/p so the first word of a promoted tile is right
    assign w_addr_nxt = ADDR_W_C'(calc_c_addr(MS_W'(w_s_nxt), MS_W'(w_p_nxt), MS_W'(w_i_nxt),
                                              MS_W'(w_j_nxt), MS_W'(M3), N1, N2));
    assign w_data_nxt = w_src_pe ? pe_result[0][0] : w_word[w_rd_bank];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_act     <= 1'b0;
            r_i       <= '0;
            r_j       <= '0;
            r_s       <= '0;
            r_p       <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_s     <= w_s_nxt;
            r_p     <= w_p_nxt;
            r_done  <= w_run_end;
            if (w_swap) begin
                r_act <= ~r_act;
            end
            if (start) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            if (w_emit) begin
                r_wr_en   <= 1'b1;
                r_i       <= w_i_nxt;
                r_j       <= w_j_nxt;
                r_wr_addr <= w_addr_nxt;
                r_wr_data <= w_data_nxt;
            end else if (w_stop) begin
                r_wr_en <= 1'b0;
            end
        end
    end

    assign wr.wr_en   = r_wr_en;
    assign wr.wr_addr = r_wr_addr;
    assign wr.wr_data = r_wr_data;
    assign busy       = (r_state != IDLE) || w_pend_full;
    assign done       = r_done;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_drain_ctrl.sv
// tb/tb_drain_ctrl.sv - randomized directed bench for drain_ctrl with a queue-based C write model
module tb_drain_ctrl;
    import drain_ctrl_pkg::*;

    localparam int N1 = 4;
    localparam int N2 = 4;
    localparam int DW = 32;
    localparam int MW = 16;
    localparam int AW = 12;

    typedef logic [N1-1:0][N2-1:0][DW-1:0] tile_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            fin;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          tile_done = 1'b0;
    logic [MW-1:0] M3 = '0;
    logic [MW-1:0] M1dN1 = '0;
    logic [MW-1:0] M3dN2 = '0;
    tile_t         pe_result = '0;
    logic          busy;
    logic          done;
    logic          overflow;

    drain_ctrl_if #(.DATA_W(DW), .ADDR_W_C(AW)) wr ();

    drain_ctrl #(.N1(N1), .N2(N2), .DATA_W(DW), .MATRIXSIZE_W(MW), .ADDR_W_C(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .M3(M3), .M1dN1(M1dN1), .M3dN2(M3dN2),
        .tile_done(tile_done), .pe_result(pe_result), .wr(wr),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int  n_assert = 0;
    int  n_fail = 0;
    wr_t exp_q[$];
    wr_t e;
    int  ms = 0;
    int  mp = 0;
    int  model_done = 0;
    int  n_done = 0;
    int  n_writes = 0;
    int  run_len = 0;
    int  max_run = 0;
    int  ready_mode = 0;
    int  cyc = 0;
    logic          exp_done = 1'b0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Expected C writes for one accepted tile, straight from the address formula
    task automatic model_tile(input tile_t t);
        wr_t w;
        for (int i = 0; i < N1; i++) begin
            for (int j = 0; j < N2; j++) begin
                w.addr = AW'(((ms * N1 + i) * int'(M3) + mp * N2 + j) % (1 << AW));
                w.data = t[i][j];
                w.fin  = (i == N1 - 1) && (j == N2 - 1) && (ms == int'(M1dN1) - 1) && (mp == int'(M3dN2) - 1);
                if (w.fin) model_done++;
                exp_q.push_back(w);
            end
        end
        mp++;
        if (mp == int'(M3dN2)) begin
            mp = 0;
            ms++;
            if (ms == int'(M1dN1)) ms = 0;
        end
    endtask

    task automatic do_start(input int m3, input int m1, input int m3d);
        M3 = MW'(m3);
        M1dN1 = MW'(m1);
        M3dN2 = MW'(m3d);
        start = 1'b1;
        ms = 0;
        mp = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_tile(input bit ramp, input bit accept);
        tile_t t;
        for (int i = 0; i < N1; i++)
            for (int j = 0; j < N2; j++)
                t[i][j] = ramp ? DW'(16 * i + j) : DW'($urandom);
        pe_result = t;
        tile_done = 1'b1;
        if (accept) model_tile(t);
        @(posedge clk); #1;
        tile_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((busy || wr.wr_en || exp_q.size() != 0) && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_idle_timeout"}, 64'(k < 3000), 1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, wr.wr_en, 0);
        check({tag, "_wr_addr"}, wr.wr_addr, 0);
        check({tag, "_wr_data"}, wr.wr_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        wr.wr_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            case (ready_mode)
                1:       wr.wr_ready = (cyc % 3) != 0;
                2:       wr.wr_ready = $urandom_range(0, 3) != 0;
                default: wr.wr_ready = 1'b1;
            endcase
        end
    end

    // Scoreboard: every transfer against the model, stall stability, done timing
    always @(negedge clk) begin
        if (rst_n) begin
            check("done_pulse", done, exp_done);
            if (done) n_done++;
            if (prev_stall) begin
                check("stall_wr_en", wr.wr_en, 1);
                check("stall_wr_addr", wr.wr_addr, prev_addr);
                check("stall_wr_data", wr.wr_data, prev_data);
            end
            run_len = wr.wr_en ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            exp_done = 1'b0;
            if (wr.wr_en && wr.wr_ready) begin
                n_writes++;
                check("write_expected", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", wr.wr_addr, e.addr);
                    check("wr_data", wr.wr_data, e.data);
                    exp_done = e.fin;
                end
            end
            prev_stall = wr.wr_en && !wr.wr_ready;
            prev_addr = wr.wr_addr;
            prev_data = wr.wr_data;
        end else begin
            exp_done = 1'b0;
            prev_stall = 1'b0;
            run_len = 0;
        end
    end

    initial begin
        int base;
        int k;
        int m1;
        int m3d;
        #1;
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("post_reset");

        // single tile, then the second tile of the same run
        ready_mode = 0;
        do_start(8, 1, 2);
        send_tile(1'b1, 1'b1);
        check("latency_wr_en", wr.wr_en, 1);
        check("first_addr", wr.wr_addr, 0);
        check("first_data", wr.wr_data, 0);
        check("busy_drain", busy, 1);
        wait_idle("tile1");
        check("no_done_mid_run", 64'(n_done), 0);
        send_tile(1'b0, 1'b1);
        wait_idle("tile2");
        check("done_after_run", 64'(n_done), 1);

        // backpressure: every third cycle stalls
        ready_mode = 1;
        do_start(8, 1, 2);
        send_tile(1'b1, 1'b1);
        wait_idle("bp1");
        send_tile(1'b0, 1'b1);
        wait_idle("bp2");
        ready_mode = 0;

        // back-to-back tiles must stream with no gap
        do_start(8, 1, 2);
        max_run = 0;
        send_tile(1'b1, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        send_tile(1'b0, 1'b1);
        wait_idle("b2b");
        check("b2b_run_len", 64'(max_run), 2 * TILE_ELEMS);
        check("b2b_overflow", overflow, 0);

        // overflow: third tile in a row is dropped
        do_start(8, 1, 2);
        base = n_writes;
        send_tile(1'b1, 1'b1);
        send_tile(1'b0, 1'b1);
        send_tile(1'b0, 1'b0);
        check("ovf_set", overflow, 1);
        wait_idle("ovf");
        check("ovf_sticky", overflow, 1);
        check("ovf_writes", 64'(n_writes - base), 2 * TILE_ELEMS);
        do_start(8, 1, 2);
        check("ovf_cleared", overflow, 0);

        // randomized runs with random stalls and sizes
        ready_mode = 2;
        for (int r = 0; r < 2; r++) begin
            m1 = $urandom_range(1, 3);
            m3d = $urandom_range(1, 3);
            do_start($urandom_range(8, 600), m1, m3d);
            for (int t = 0; t < m1 * m3d; t++) begin
                k = 0;
                while (exp_q.size() > TILE_ELEMS && k < 3000) begin
                    @(posedge clk); #1;
                    k++;
                end
                check("rand_room", 64'(k < 3000), 1);
                send_tile(1'b0, 1'b1);
                repeat ($urandom_range(0, 20)) begin @(posedge clk); #1; end
            end
            wait_idle("rand");
        end
        ready_mode = 0;

        // reset in the middle of a drain
        do_start(8, 1, 2);
        base = n_writes;
        send_tile(1'b0, 1'b1);
        k = 0;
        while (n_writes < base + 5 && k < 200) begin
            @(posedge clk);
            k++;
        end
        check("rst_wait", 64'(k < 200), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        exp_q.delete();
        ms = 0;
        mp = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_tile(1'b1, 1'b1);
        check("post_rst_addr", wr.wr_addr, 0);
        wait_idle("post_rst");

        check("queue_drained", 64'(exp_q.size()), 0);
        check("done_count", 64'(n_done), 64'(model_done));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/drain_ctrl.md
# drain_ctrl

Write-side controller for the N1×N2 systolic matrix-multiply array. It runs opposite to the read-address controller that feeds operands A and B. On each tile-complete pulse it snapshots the array's N1×N2 accumulator results, then streams them one word per cycle into the output buffer C (M1×M3, row-major). It generates C write addresses using the same tile ordering the read side uses: A slice outer, B patch inner.

## Interface
- N1, 4: array rows
- N2, 4: array columns
- DATA_W, 32: result word width
- MATRIXSIZE_W, 16: width of size inputs and internal counters
- ADDR_W_C, 12: C buffer address width

- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  one-cycle pulse; clears tile counters and overflow, starts a new run
- M3  in  MATRIXSIZE_W  C row length (columns)
- M1dN1  in  MATRIXSIZE_W  A slices per run
- M3dN2  in  MATRIXSIZE_W  B patches per slice
- tile_done  in  1  one-cycle pulse: pe_result holds a finished tile
- pe_result  in  DATA_W, [N1][N2]  accumulator outputs
- wr_en  out  1  C write valid
- wr_ready  in  1  C buffer accepts the write
- wr_addr  out  ADDR_W_C  C write address
- wr_data  out  DATA_W  C write data
- busy  out  1  a drain is in progress or a tile is pending
- done  out  1  one-cycle pulse after the last word of the run transfers
- overflow  out  1  sticky flag: a tile was dropped

## Operation
- Two result banks:
  - active: being drained
  - pending: captured but not yet draining
- tile_done behaviour:
  - active empty: capture into active.
  - active full, pending empty: capture into pending.
  - both full: drop the tile and set overflow; counters do not advance.
- FSM states:
  - IDLE: active empty. tile_done → DRAIN.
  - DRAIN: emit elements. On the last element transfer, if pending is full, move pending to active and stay in DRAIN; otherwise go to IDLE.
- Element order within a tile: i outer (0..N1-1), j inner (0..N2-1).
- Address: wr_addr = (s·N1 + i)·M3 + p·N2 + j, truncated to ADDR_W_C.
  - s = slice counter, 0..M1dN1-1.
  - p = patch counter, 0..M3dN2-1.
- Counter advance: after each tile's last transfer, p increments. When p wraps from M3dN2-1 to 0, s increments.
- End of run: when s=M1dN1-1 and p=M3dN2-1 wrap, pulse done and return s and p to 0.
- start:
  - Zeroes s, p and overflow.
  - Does not discard banks that are already captured.
  - If start and a tile-end fall in the same cycle, start wins.
- Products use MATRIXSIZE_W×2-bit intermediates.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0, FSM=IDLE, both banks empty, all counters 0.
- Latency: first wr_en rises the cycle after tile_done is sampled (with IDLE and active empty).
- Handshake: a transfer occurs on any cycle with wr_en && wr_ready. While wr_ready=0, wr_en, wr_addr and wr_data hold stable.
- Throughput: N1·N2 cycles per tile with wr_ready held high; no bubble between back-to-back tiles when pending is full.
- Coincident events:
  - tile_done in the same cycle as the active bank's last transfer: the new tile captures into pending and is promoted next cycle without loss.
  - If pending was already full in that cycle, the promotion frees pending and the new tile captures into it.
- busy = FSM≠IDLE or pending full.
- done asserts for exactly one cycle, registered, the cycle after the final transfer.
- rst_n asserted mid-drain: everything returns to reset values immediately; partial tiles are lost.

## Structure
- Shared package provides:
  - drain_state_t enum (IDLE, DRAIN)
  - localparam TILE_ELEMS = N1·N2
  - address function calc_c_addr(s, p, i, j, M3)
- Sub-module tile_bank: one N1×N2 DATA_W register bank with load, full flag and read mux by (i, j). Instantiate it twice.
- FSM, the i/j/s/p counters and the output registers live in the top level.

## Test plan
- Single tile: N1=N2=4, M3=8, M1dN1=1, M3dN2=2, pe_result[i][j]=16i+j, wr_ready=1.
  - Expect 16 writes: addresses 0,1,2,3,8,9,…,27; data 0..3, 16..19, …
- Second tile of the same run: expect addresses 4..7, 12..15, 20..23, 28..31. done pulses one cycle after write 32.
- Backpressure: drop wr_ready on every third cycle.
  - Addresses and data hold while stalled.
  - Write sequence is identical to the unstalled run.
  - No duplicates or skips.
- Back-to-back: a second tile_done during drain with wr_ready=1.
  - 32 consecutive wr_en cycles with no gap.
  - overflow stays 0.
- Overflow: three tile_done pulses within 4 cycles.
  - Third tile dropped; overflow=1 stays set until start.
  - Exactly 32 writes.
- Reset mid-drain: assert rst_n=0 after write 5.
  - All outputs return to 0 asynchronously.
  - Next tile writes start at address 0.
